muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit that owns the HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//  Consumes the two register-file read operands (rs, rt).
//  HI/LO feed the MFHI/MFLO writeback mux.
//  Control stalls the core while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH bits each; one iteration per cycle, WIDTH iterations
// PORTS
//  clock    in   1      clock; all state updates on posedge
//  reset    in   1      asynchronous, active-high
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data  in   WIDTH  operand A (multiplicand / dividend)
//  rt_data  in   WIDTH  operand B (multiplier / divisor)
//  mthi     in   1      write rs_data to hi (IDLE only)
//  mtlo     in   1      write rs_data to lo (IDLE only)
//  busy     out  1      high from the cycle after an accepted start until done
//  done     out  1      one-cycle pulse; hi/lo valid the same cycle
//  hi       out  WIDTH  HI register (product high half / remainder)
//  lo       out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; all internal accumulators cleared.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: on start, latch operands.
//    Signed ops latch absolute values and record result signs.
//    Set count=WIDTH-1, go to RUN.
//   RUN: one radix-2 step per cycle.
//    Multiply: shift-add into a 2*WIDTH accumulator.
//    Divide: restoring shift-subtract.
//    When count==0, go to FIX; otherwise decrement count.
//   FIX: apply signs. hi/lo are written at this edge. done=1 for one cycle. Go to IDLE.
//  Latency: start accepted at edge N; busy=1 for cycles N+1..N+WIDTH+1; done at cycle N+WIDTH+1.
//  busy and done are both high in the FIX cycle. A new start is accepted in the cycle after done.
//  Arithmetic:
//   MULT: 2*WIDTH two's-complement product.
//   MULTU: 2*WIDTH unsigned product.
//   DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
//   The most-negative value divided by -1 gives lo=most-negative, hi=0 (no trap).
//   Divide by zero, both signed and unsigned: lo = all ones, hi = rs_data. Takes the full latency.
//  Boundary rules:
//   start while busy: ignored; in-flight op unaffected.
//   mthi/mtlo while busy: ignored; no queueing.
//   mthi/mtlo in IDLE: hi/lo written at the next edge.
//   start together with mthi/mtlo in IDLE: start wins; the move is dropped.
//   reset mid-operation: abort immediately; hi/lo cleared; no done pulse.
//   hi/lo hold their values between operations.
// CONFIGURATION
//  MULDIV_DIV_EN defined: divide datapath is built; DIV/DIVU behave as above.
//  MULDIV_DIV_EN undefined: no divider logic.
//   DIV/DIVU start goes IDLE->FIX directly: busy=1 for one cycle, done at N+1, hi/lo unchanged.
//   Multiply timing is unchanged.
// STRUCTURE
//  Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encodings.
//  The same package also holds the WIDTH default.
//  The control package reuses the op encodings for funct decode.
//  One sub-module: muldiv_core, the per-cycle shift/add/subtract step datapath.
//  The top level holds the FSM, sign handling and the HI/LO registers.
// TESTING
//  MULT rs=0xFFFFFFFD(-3), rt=5 -> done at N+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
//  DIV rs=-7, rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//   DIV rs=0x80000000, rt=-1 -> lo=0x80000000, hi=0.
//  DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064.
//   Without MULDIV_DIV_EN: done at N+1, hi/lo unchanged.
//  MULTU 6*7 started; second start (op=DIVU) plus mthi at cycle N+5 -> both ignored; hi=0, lo=42.
//   Then mtlo rs=0x1234 in IDLE -> lo=0x1234 next cycle.
//  Reset asserted at cycle N+10 of a MULT -> busy=0, hi=lo=0 immediately; no done pulse.
//   A new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the multiply/divide unit.
//   - WIDTH_DEFAULT : default operand width (hi/lo are WIDTH bits each)
//   - op_e          : MULT/MULTU/DIV/DIVU encodings. The control decoder uses
//                     the same encodings for funct decode.
//   - state_e       : FSM state encodings (IDLE -> RUN -> FIX -> IDLE)
//   - helper functions classifying an op as divide and/or signed
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Command/result bundle between the core pipeline and the multiply/divide
//   unit.
//   master (pipeline side) drives : start, op, rs_data, rt_data, mthi, mtlo
//   slave  (muldiv side) drives   : busy, done, hi, lo
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int WIDTH = muldiv_unit_pkg::WIDTH_DEFAULT
) ();
  import muldiv_unit_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
//   Purely combinational single radix-2 step of the iterative multiplier /
//   restoring divider. The caller registers acc_out and feeds it back.
//   Ports:
//     is_div  in  1        select divide step (only present with MULDIV_DIV_EN)
//     operand in  WIDTH    multiplicand (multiply) or divisor (divide), unsigned
//     acc_in  in  2*WIDTH  multiply: {partial product, remaining multiplier}
//                          divide  : {partial remainder, remaining dividend/quotient}
//     acc_out out 2*WIDTH  accumulator after one step
//   Configuration macro: MULDIV_DIV_EN builds the divide step; without it the
//   core is a multiply step only.
// -----------------------------------------------------------------------------
module muldiv_core
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  input  logic [WIDTH-1:0]   operand,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (acc lsb) is set, then shift the whole accumulator right.
  // The extra sum bit keeps the carry, which lands in the top of the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;

  always_comb begin
    mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    mul_acc = {mul_sum, acc_in[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // Restoring divide: shift {rem, dividend} left one bit; the trial remainder
  // needs WIDTH+1 bits because 2*rem+bit can reach 2*divisor-1.
  logic [WIDTH:0]     div_top;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_acc;

  always_comb begin
    div_top  = acc_in[2*WIDTH-1:WIDTH-1];
    // Only used when div_top >= operand, so the true difference fits WIDTH bits.
    div_diff = div_top[WIDTH-1:0] - operand;
    if (div_top >= {1'b0, operand}) begin
      div_acc = {div_diff, acc_in[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {div_top[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end
  end

  assign acc_out = is_div ? div_acc : mul_acc;
`else
  assign acc_out = mul_acc;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO registers
//   (MULT, MULTU, DIV, DIVU, MTHI, MTLO). One radix-2 step per cycle.
//   Ports:
//     clock  in  1   all state updates on posedge
//     reset  in  1   asynchronous, active-high; aborts any operation
//     bus    slave muldiv_unit_if: start/op/rs_data/rt_data/mthi/mtlo in,
//                  busy/done/hi/lo out
//   Timing: start accepted at edge N -> busy for WIDTH+1 cycles, done pulse in
//   the last of them with hi/lo already updated.
//   Configuration macro: MULDIV_DIV_EN builds the divider. Without it DIV/DIVU
//   pass straight to FIX (one busy cycle, done, hi/lo untouched).
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   operand_reg;
  logic               neg_lo_reg;   // negate product (mult) / quotient (div)
  logic [WIDTH-1:0]   hi_reg, lo_reg;

`ifdef MULDIV_DIV_EN
  logic               is_div_reg;
  logic               neg_hi_reg;   // remainder follows the dividend sign
  logic               div_zero_reg;
  logic [WIDTH-1:0]   dividend_reg; // raw rs, returned in hi on divide-by-zero
`endif

  // Operand preparation: signed ops work on magnitudes, signs fixed at the end.
  logic             start_div;
  logic             start_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    start_div    = op_is_div(bus.op);
    start_signed = op_is_signed(bus.op);
    a_neg        = start_signed & bus.rs_data[WIDTH-1];
    b_neg        = start_signed & bus.rt_data[WIDTH-1];
    a_abs        = a_neg ? -bus.rs_data : bus.rs_data;
    b_abs        = b_neg ? -bus.rt_data : bus.rt_data;
  end

  muldiv_core #(
    .WIDTH   (WIDTH)
  ) u_core (
`ifdef MULDIV_DIV_EN
    .is_div  (is_div_reg),
`endif
    .operand (operand_reg),
    .acc_in  (acc_reg),
    .acc_out (step_acc)
  );

  // Final result is formed from the last step's combinational output so that
  // hi/lo are already valid in the FIX cycle alongside done.
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    product = neg_lo_reg ? -step_acc : step_acc;
    res_hi  = product[2*WIDTH-1:WIDTH];
    res_lo  = product[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div_reg) begin
      if (div_zero_reg) begin
        res_lo = '1;
        res_hi = dividend_reg;
      end else begin
        res_lo = neg_lo_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        res_hi = neg_hi_reg ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef MULDIV_DIV_EN
          state_next = ST_RUN;
`else
          state_next = start_div ? ST_FIX : ST_RUN;
`endif
        end
      end
      ST_RUN:  if (count_reg == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      neg_lo_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
`ifdef MULDIV_DIV_EN
      is_div_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      dividend_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            // start takes priority; a simultaneous mthi/mtlo is dropped
            count_reg   <= CW'(WIDTH - 1);
            neg_lo_reg  <= a_neg ^ b_neg;
            acc_reg     <= {{WIDTH{1'b0}}, b_abs};
            operand_reg <= a_abs;
`ifdef MULDIV_DIV_EN
            is_div_reg   <= start_div;
            neg_hi_reg   <= a_neg;
            div_zero_reg <= start_div & (bus.rt_data == '0);
            dividend_reg <= bus.rs_data;
            if (start_div) begin
              acc_reg     <= {{WIDTH{1'b0}}, a_abs};
              operand_reg <= b_abs;
            end
`endif
          end else begin
            if (bus.mthi) hi_reg <= bus.rs_data;
            if (bus.mtlo) lo_reg <= bus.rs_data;
          end
        end
        ST_RUN: begin
          acc_reg   <= step_acc;
          count_reg <= count_reg - 1'b1;
          if (count_reg == '0) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg != ST_IDLE);
  assign bus.done = (state_reg == ST_FIX);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule
